// File: rtl/de_pipe_reg.sv
// Decode-to-execute pipeline register with stall hold, flush bubble insertion,
// writeback refresh/write-through of operands and a saturating bubble counter.
module de_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_D,
  input  logic             rd_wr_D,
  input  logic             is_load_D,
  input  logic             is_store_D,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rd_addr_D,
  input  logic [3:0]       alu_op_D,
  input  logic [XLEN-1:0]  pc_D,
  input  logic [XLEN-1:0]  imm_D,
  input  logic [XLEN-1:0]  rs1_data_D,
  input  logic [XLEN-1:0]  rs2_data_D,
  input  logic             rd_wr_W,
  input  logic [4:0]       rd_addr_W,
  input  logic [XLEN-1:0]  rd_data_W,
  output logic             valid_E,
  output logic             rd_wr_E,
  output logic             is_load_E,
  output logic             is_store_E,
  output logic [4:0]       rs1_addr_D_E,
  output logic [4:0]       rs2_addr_D_E,
  output logic [4:0]       rd_addr_E,
  output logic [3:0]       alu_op_E,
  output logic [XLEN-1:0]  pc_E,
  output logic [XLEN-1:0]  imm_E,
  output logic [XLEN-1:0]  rs1_data_E,
  output logic [XLEN-1:0]  rs2_data_E,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic             r_valid, r_rd_wr, r_is_load, r_is_store;
  logic [4:0]       r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [3:0]       r_alu_op;
  logic [XLEN-1:0]  r_pc, r_imm, r_rs1_data, r_rs2_data;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic w_wb_live;
  logic w_rs1_refresh, w_rs2_refresh;
  logic w_rs1_bypass, w_rs2_bypass;
  logic w_cnt_sat;

  // x0 is hardwired zero, so a writeback to it must never override operands.
  assign w_wb_live     = rd_wr_W & (rd_addr_W != 5'd0);
  assign w_rs1_refresh = r_valid & w_wb_live & (rd_addr_W == r_rs1_addr);
  assign w_rs2_refresh = r_valid & w_wb_live & (rd_addr_W == r_rs2_addr);
  assign w_rs1_bypass  = w_wb_live & (rd_addr_W == rs1_addr_D);
  assign w_rs2_bypass  = w_wb_live & (rd_addr_W == rs2_addr_D);
  assign w_cnt_sat     = &r_bubble_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_rd_wr    <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_alu_op   <= '0;
      r_pc       <= '0;
      r_imm      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (flush_i) begin
      // Bubble: kill control and zero addresses so hazard compares never hit.
      r_valid    <= 1'b0;
      r_rd_wr    <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
    end else if (stall_i) begin
      if (w_rs1_refresh) r_rs1_data <= rd_data_W;
      if (w_rs2_refresh) r_rs2_data <= rd_data_W;
    end else begin
      r_valid    <= valid_D;
      r_rd_wr    <= rd_wr_D;
      r_is_load  <= is_load_D;
      r_is_store <= is_store_D;
      r_rs1_addr <= rs1_addr_D;
      r_rs2_addr <= rs2_addr_D;
      r_rd_addr  <= rd_addr_D;
      r_alu_op   <= alu_op_D;
      r_pc       <= pc_D;
      r_imm      <= imm_D;
      r_rs1_data <= w_rs1_bypass ? rd_data_W : rs1_data_D;
      r_rs2_data <= w_rs2_bypass ? rd_data_W : rs2_data_D;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if ((flush_i | stall_i) && !w_cnt_sat) begin
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign valid_E      = r_valid;
  assign rd_wr_E      = r_rd_wr;
  assign is_load_E    = r_is_load;
  assign is_store_E   = r_is_store;
  assign rs1_addr_D_E = r_rs1_addr;
  assign rs2_addr_D_E = r_rs2_addr;
  assign rd_addr_E    = r_rd_addr;
  assign alu_op_E     = r_alu_op;
  assign pc_E         = r_pc;
  assign imm_E        = r_imm;
  assign rs1_data_E   = r_rs1_data;
  assign rs2_data_E   = r_rs2_data;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg: vector table for load/stall/flush/bypass,
// plus hand sequences for counter saturation and reset during a stall.
module tb_de_pipe_reg;

  logic        clk_i, rst_i, stall_i, flush_i;
  logic        valid_D, rd_wr_D, is_load_D, is_store_D;
  logic [4:0]  rs1_addr_D, rs2_addr_D, rd_addr_D, rd_addr_W;
  logic [3:0]  alu_op_D;
  logic [31:0] pc_D, imm_D, rs1_data_D, rs2_data_D, rd_data_W;
  logic        rd_wr_W;
  logic        valid_E, rd_wr_E, is_load_E, is_store_E;
  logic [4:0]  rs1_addr_D_E, rs2_addr_D_E, rd_addr_E;
  logic [3:0]  alu_op_E;
  logic [31:0] pc_E, imm_E, rs1_data_E, rs2_data_E;
  logic [3:0]  bubble_cnt_o;

  int total = 0;
  int bad   = 0;

  de_pipe_reg #(.XLEN(32), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_D(valid_D), .rd_wr_D(rd_wr_D), .is_load_D(is_load_D), .is_store_D(is_store_D),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D), .rd_addr_D(rd_addr_D),
    .alu_op_D(alu_op_D), .pc_D(pc_D), .imm_D(imm_D),
    .rs1_data_D(rs1_data_D), .rs2_data_D(rs2_data_D),
    .rd_wr_W(rd_wr_W), .rd_addr_W(rd_addr_W), .rd_data_W(rd_data_W),
    .valid_E(valid_E), .rd_wr_E(rd_wr_E), .is_load_E(is_load_E), .is_store_E(is_store_E),
    .rs1_addr_D_E(rs1_addr_D_E), .rs2_addr_D_E(rs2_addr_D_E), .rd_addr_E(rd_addr_E),
    .alu_op_E(alu_op_E), .pc_E(pc_E), .imm_E(imm_E),
    .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E), .bubble_cnt_o(bubble_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned stall, flush, valid, rd_wr, ld, st, rs1a, rs2a, rda, alu;
    int unsigned pc, imm, rs1d, rs2d, wwr, wa, wd;
    int unsigned e_valid, e_rd_wr, e_ld, e_st, e_rs1a, e_rs2a, e_rda, e_alu;
    int unsigned e_pc, e_imm, e_rs1d, e_rs2d, e_cnt;
  } vec_t;

  vec_t vecs[16];
  vec_t zero_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input vec_t v);
    stall_i    = v.stall[0];
    flush_i    = v.flush[0];
    valid_D    = v.valid[0];
    rd_wr_D    = v.rd_wr[0];
    is_load_D  = v.ld[0];
    is_store_D = v.st[0];
    rs1_addr_D = v.rs1a[4:0];
    rs2_addr_D = v.rs2a[4:0];
    rd_addr_D  = v.rda[4:0];
    alu_op_D   = v.alu[3:0];
    pc_D       = v.pc;
    imm_D      = v.imm;
    rs1_data_D = v.rs1d;
    rs2_data_D = v.rs2d;
    rd_wr_W    = v.wwr[0];
    rd_addr_W  = v.wa[4:0];
    rd_data_W  = v.wd;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".valid"}, 32'(valid_E),      v.e_valid);
    check({tag, ".rd_wr"}, 32'(rd_wr_E),      v.e_rd_wr);
    check({tag, ".ld"},    32'(is_load_E),    v.e_ld);
    check({tag, ".st"},    32'(is_store_E),   v.e_st);
    check({tag, ".rs1a"},  32'(rs1_addr_D_E), v.e_rs1a);
    check({tag, ".rs2a"},  32'(rs2_addr_D_E), v.e_rs2a);
    check({tag, ".rda"},   32'(rd_addr_E),    v.e_rda);
    check({tag, ".alu"},   32'(alu_op_E),     v.e_alu);
    check({tag, ".pc"},    pc_E,              v.e_pc);
    check({tag, ".imm"},   imm_E,             v.e_imm);
    check({tag, ".rs1d"},  rs1_data_E,        v.e_rs1d);
    check({tag, ".rs2d"},  rs2_data_E,        v.e_rs2d);
    check({tag, ".cnt"},   32'(bubble_cnt_o), v.e_cnt);
  endtask

  initial begin
    //          stl flu val rdw ld st rs1 rs2 rd alu pc     imm   rs1d    rs2d    wwr wa wd        | eval erdw eld est ers1 ers2 erd ealu epc    eimm  ers1d   ers2d   ecnt
    vecs[0]  = '{0, 0, 1, 1, 0, 0, 1,  2,  5,  3, 'h100, 'h10, 'hAA,   'hBB,   0, 0,  0,        1, 1, 0, 0, 1,  2,  5,  3, 'h100, 'h10, 'hAA,   'hBB,   0};
    vecs[1]  = '{0, 0, 1, 1, 1, 0, 3,  7,  4,  4, 'h104, 'h20, 'h22,   'h11,   1, 7,  'h55,     1, 1, 1, 0, 3,  7,  4,  4, 'h104, 'h20, 'h22,   'h55,   0};
    vecs[2]  = '{0, 0, 1, 0, 0, 1, 0,  0,  6,  5, 'h108, 'h30, 'h33,   'h11,   1, 0,  'h99,     1, 0, 0, 1, 0,  0,  6,  5, 'h108, 'h30, 'h33,   'h11,   0};
    vecs[3]  = '{0, 0, 1, 1, 0, 0, 3,  9,  8,  6, 'h10C, 'h40, 'h44,   'h66,   1, 3,  'h77,     1, 1, 0, 0, 3,  9,  8,  6, 'h10C, 'h40, 'h77,   'h66,   0};
    vecs[4]  = '{1, 0, 0, 1, 1, 1, 12, 13, 14, 9, 'h200, 'h50, 'hDEAD, 'hBEEF, 0, 0,  0,        1, 1, 0, 0, 3,  9,  8,  6, 'h10C, 'h40, 'h77,   'h66,   1};
    vecs[5]  = '{1, 0, 0, 1, 1, 1, 12, 13, 14, 9, 'h200, 'h50, 'hDEAD, 'hBEEF, 1, 3,  'h1234,   1, 1, 0, 0, 3,  9,  8,  6, 'h10C, 'h40, 'h1234, 'h66,   2};
    vecs[6]  = '{0, 0, 0, 1, 1, 1, 12, 13, 14, 9, 'h200, 'h50, 'hDEAD, 'hBEEF, 0, 0,  0,        0, 1, 1, 1, 12, 13, 14, 9, 'h200, 'h50, 'hDEAD, 'hBEEF, 2};
    vecs[7]  = '{1, 0, 0, 1, 1, 1, 12, 13, 14, 9, 'h200, 'h50, 'hDEAD, 'hBEEF, 1, 12, 'h5555,   0, 1, 1, 1, 12, 13, 14, 9, 'h200, 'h50, 'hDEAD, 'hBEEF, 3};
    vecs[8]  = '{0, 0, 1, 1, 0, 0, 5,  6,  7,  2, 'h300, 'h60, 1,      2,      0, 0,  0,        1, 1, 0, 0, 5,  6,  7,  2, 'h300, 'h60, 1,      2,      3};
    vecs[9]  = '{1, 1, 1, 1, 1, 1, 8,  8,  8,  1, 'h400, 'h70, 3,      4,      0, 0,  0,        0, 0, 0, 0, 0,  0,  0,  2, 'h300, 'h60, 1,      2,      4};
    vecs[10] = '{1, 0, 1, 1, 1, 1, 8,  8,  8,  1, 'h400, 'h70, 3,      4,      1, 0,  'hEE,     0, 0, 0, 0, 0,  0,  0,  2, 'h300, 'h60, 1,      2,      5};
    vecs[11] = '{0, 0, 1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'h20,   0, 0,  0,        1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'h20,   5};
    vecs[12] = '{1, 0, 1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'h20,   1, 5,  'hAB,     1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'hAB,   6};
    vecs[13] = '{1, 0, 1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'h20,   0, 5,  'hCD,     1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'hAB,   7};
    vecs[14] = '{0, 1, 1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'h20,   0, 0,  0,        0, 0, 0, 0, 0,  0,  0,  7, 'h400, 'h70, 'h10,   'hAB,   8};
    vecs[15] = '{0, 0, 1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h10,   'h20,   1, 4,  'h99,     1, 1, 1, 1, 4,  5,  1,  7, 'h400, 'h70, 'h99,   'h20,   8};
    zero_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset wins over flush/stall and junk decode inputs.
    drive(vecs[9]);
    rst_i = 1'b1;
    step();
    step();
    check_vec("reset", zero_v);
    rst_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      step();
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Saturation of a 4-bit counter under a long stall.
    drive(zero_v);
    rst_i = 1'b1;
    step();
    check("sat.cnt_reset", 32'(bubble_cnt_o), 32'd0);
    rst_i   = 1'b0;
    stall_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 13) check("sat.cnt14", 32'(bubble_cnt_o), 32'hE);
      if (k == 14) check("sat.cnt15", 32'(bubble_cnt_o), 32'hF);
    end
    check("sat.cnt_hold", 32'(bubble_cnt_o), 32'hF);

    // Reset asserted while an instruction is held by a stall.
    stall_i = 1'b0; valid_D = 1'b1; rd_wr_D = 1'b1; rs1_addr_D = 5'd2; rd_addr_D = 5'd9;
    pc_D = 32'h500; rs1_data_D = 32'hAB;
    step();
    check("rms.load_pc", pc_E, 32'h500);
    stall_i = 1'b1; pc_D = 32'h5FF;
    step();
    check("rms.held_pc", pc_E, 32'h500);
    rst_i = 1'b1; flush_i = 1'b1;
    step();
    check("rms.valid", 32'(valid_E), 32'd0);
    check("rms.pc", pc_E, 32'd0);
    check("rms.rs1d", rs1_data_E, 32'd0);
    check("rms.rda", 32'(rd_addr_E), 32'd0);
    check("rms.rs1a", 32'(rs1_addr_D_E), 32'd0);
    check("rms.cnt", 32'(bubble_cnt_o), 32'd0);
    rst_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    pc_D = 32'h600; rd_addr_D = 5'd10; rs1_data_D = 32'hCD;
    step();
    check("rel.valid", 32'(valid_E), 32'd1);
    check("rel.pc", pc_E, 32'h600);
    check("rel.rda", 32'(rd_addr_E), 32'd10);
    check("rel.rs1d", rs1_data_E, 32'hCD);
    check("rel.cnt", 32'(bubble_cnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
